rs232_rx: RTL and testbench

- Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first; idle line high.
- Pairs with the team's RS232 transmitter at the same bit rate: TICKS clocks per bit, 1302 at 25 MHz for 19200 bps.
- Sits between the board RxD pin and the CPU I/O port.
- Delivers one byte per frame through a rdy/done handshake, with framing-error and overrun flags.

---
 rtl/rs232_rx.sv | 155 +++++++++++++++
 tb/tb_rs232_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: two-flop synchronizer, centre-sampling FSM, and a rdy/done
// handshake carrying sticky framing-error and overrun flags.
module rs232_rx #(
    parameter int TICKS = 1302,
    parameter int HALF  = TICKS / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       done,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       ovr,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [11:0] TICK_LAST = 12'(TICKS - 1);
    localparam logic [11:0] HALF_LAST = 12'(HALF - 1);

    state_t      state_q,  state_d;
    logic        s1_q,     s1_d;
    logic        s2_q,     s2_d;
    logic        prev_q,   prev_d;
    logic [11:0] tick_q,   tick_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q,  shreg_d;
    logic [7:0]  data_q,   data_d;
    logic        rdy_q,    rdy_d;
    logic        ferr_q,   ferr_d;
    logic        ovr_q,    ovr_d;
    logic        rxs;
    logic        complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prev_q   <= 1'b1;
            tick_q   <= 12'd0;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'd0;
            data_q   <= 8'd0;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            tick_q   <= tick_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        s1_d     = RxD;
        s2_d     = s1_q;
        rxs      = s2_q;
        prev_d   = rxs;
        state_d  = state_q;
        tick_d   = tick_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a high-to-low transition starts a frame, so a held-low break is ignored.
                if (!rxs && prev_q) begin
                    state_d = START;
                    tick_d  = 12'd0;
                end
            end
            START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d = 12'd0;
                    if (!rxs) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 12'd1;
                end
            end
            DATA: begin
                if (tick_q == TICK_LAST) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    tick_d  = 12'd0;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 12'd1;
                end
            end
            STOP: begin
                if (tick_q == TICK_LAST) begin
                    complete = 1'b1;
                    tick_d   = 12'd0;
                    state_d  = IDLE;
                end else begin
                    tick_d = tick_q + 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 12'd0;
            end
        endcase

        // A completion beats a same-cycle done; done only consumes a byte that was pending.
        if (complete) begin
            data_d = shreg_q;
            rdy_d  = 1'b1;
            ferr_d = ~rxs | (ferr_q & ~done);
            ovr_d  = rdy_q & ~done;
        end else if (done && rdy_q) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign ferr      = ferr_q;
    assign ovr       = ovr_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: a serial-line driver pushes expected bytes, and a monitor
// pops and compares each time the receiver presents a byte.
module tb_rs232_rx;
  localparam int TICKS = 16;
  localparam int HALF  = 8;
  localparam int LAT_NOM = 2 + HALF + 9 * TICKS;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       done;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       ovr;
  logic       busy;
  logic [1:0] dbg_state;

  rs232_rx #(.TICKS(TICKS), .HALF(HALF)) dut (
    .clk(clk), .rst(rst), .RxD(RxD), .done(done),
    .data(data), .rdy(rdy), .ferr(ferr), .ovr(ovr), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected byte, flags and the cycle of the start-bit falling edge
  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       ov;
    int         t0;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference model of what the consumer should see
  logic       m_pending = 1'b0;
  logic       m_ferr    = 1'b0;
  logic [7:0] m_data    = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame; optionally pulse done in the exact completion cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic done_at_end,
                            input int gap);
    exp_t e;
    RxD = 1'b1;
    tick_n(gap);
    e.d  = b;
    e.ov = m_pending && !done_at_end;
    e.fe = !stop || (m_pending && !done_at_end && m_ferr);
    e.t0 = cyc;
    exp_q.push_back(e);
    m_pending = 1'b1;
    m_ferr    = e.fe;
    m_data    = b;
    RxD = 1'b0;
    tick_n(TICKS);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick_n(TICKS);
    end
    RxD = stop;
    if (done_at_end) begin
      tick_n(LAT_NOM - 1 - 9 * TICKS);
      done = 1'b1;
      tick_n(1);
      done = 1'b0;
      tick_n(TICKS - (LAT_NOM - 9 * TICKS));
    end else begin
      tick_n(TICKS);
    end
  endtask

  task automatic do_done();
    done = 1'b1;
    tick_n(1);
    done = 1'b0;
    m_pending = 1'b0;
    m_ferr    = 1'b0;
    check("rdy_after_done", 32'(rdy), 32'(0));
    check("ferr_after_done", 32'(ferr), 32'(0));
    check("ovr_after_done", 32'(ovr), 32'(0));
  endtask

  // monitor / scoreboard
  logic       rdy_p  = 1'b0;
  logic       ovr_p  = 1'b0;
  logic [7:0] data_p = 8'd0;
  always @(negedge clk) begin
    if (rst !== 1'b1 && rdy === 1'b1 &&
        (rdy_p !== 1'b1 || data !== data_p || (ovr === 1'b1 && ovr_p !== 1'b1))) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h with nothing expected (cycle %0d)", data, cyc);
      end else begin
        exp_t e;
        int lat;
        e = exp_q.pop_front();
        lat = cyc - e.t0;
        check("sb_data", 32'(data), 32'(e.d));
        check("sb_ferr", 32'(ferr), 32'(e.fe));
        check("sb_ovr", 32'(ovr), 32'(e.ov));
        total++;
        if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
          bad++;
          $display("FAIL sb_latency: got %0d expected %0d+-1", lat, LAT_NOM);
        end
      end
    end
    rdy_p  = rdy;
    ovr_p  = ovr;
    data_p = data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int busy_hi;
    logic saw_busy;
    logic [7:0] b;
    logic stop;

    rst  = 1'b1;
    RxD  = 1'b1;
    done = 1'b0;
    tick_n(3);
    rst = 1'b0;
    tick_n(2);
    check("reset_data", 32'(data), 32'(0));
    check("reset_rdy", 32'(rdy), 32'(0));
    check("reset_ferr", 32'(ferr), 32'(0));
    check("reset_ovr", 32'(ovr), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));

    // single frame, consumed a few cycles later
    send_frame(8'h55, 1'b1, 1'b0, 4);
    tick_n(2);
    check("t1_rdy", 32'(rdy), 32'(1));
    do_done();

    // back-to-back frames without consumption -> overrun
    send_frame(8'hA3, 1'b1, 1'b0, 3);
    send_frame(8'h0F, 1'b1, 1'b0, 3);
    check("t2_data", 32'(data), 32'(8'h0F));
    check("t2_rdy", 32'(rdy), 32'(1));
    check("t2_ovr", 32'(ovr), 32'(1));
    do_done();

    // low stop bit, then a held-low break
    send_frame(8'h81, 1'b0, 1'b0, 3);
    busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick_n(1);
      if (busy === 1'b1) busy_hi++;
    end
    check("t3_break_busy", 32'(busy_hi), 32'(0));
    check("t3_ferr", 32'(ferr), 32'(1));
    check("t3_data", 32'(data), 32'(8'h81));
    do_done();
    RxD = 1'b1;
    tick_n(5);
    check("t3_idle_after_break", 32'(busy), 32'(0));

    // short glitch on an idle line
    saw_busy = 1'b0;
    RxD = 1'b0;
    tick_n(3);
    RxD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    check("t4_glitch_seen", 32'(saw_busy), 32'(1));
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_rdy", 32'(rdy), 32'(m_pending));
    check("t4_data", 32'(data), 32'(m_data));

    // done in the very cycle the second frame completes
    send_frame(8'h11, 1'b1, 1'b0, 3);
    send_frame(8'h22, 1'b1, 1'b1, 3);
    check("t5_rdy", 32'(rdy), 32'(1));
    check("t5_data", 32'(data), 32'(8'h22));
    check("t5_ovr", 32'(ovr), 32'(0));
    do_done();

    // reset in the middle of data bit 4, then a clean frame
    b = 8'h5A;
    RxD = 1'b1;
    tick_n(3);
    RxD = 1'b0;
    tick_n(TICKS);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      tick_n(TICKS);
    end
    RxD = b[4];
    tick_n(5);
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    RxD = 1'b1;
    m_pending = 1'b0;
    m_ferr    = 1'b0;
    m_data    = 8'd0;
    tick_n(2);
    check("t6_data", 32'(data), 32'(0));
    check("t6_rdy", 32'(rdy), 32'(0));
    check("t6_ferr", 32'(ferr), 32'(0));
    check("t6_ovr", 32'(ovr), 32'(0));
    check("t6_busy", 32'(busy), 32'(0));
    send_frame(8'hC6, 1'b1, 1'b0, 3);
    do_done();

    // randomized frames, stop bits, gaps and consumption
    for (int n = 0; n < 12; n++) begin
      do b = 8'($urandom_range(0, 255)); while (m_pending && b == m_data);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, 1'b0, $urandom_range(3, 12));
      tick_n($urandom_range(0, 6));
      if ($urandom_range(0, 2) != 0) do_done();
    end
    if (m_pending) do_done();

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick_n(1);
    check("sb_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
